// File: rtl/mem_bus_seq_pkg.sv
// mem_pkg: shared definitions for the mem_bus_seq word-memory sequencer.
//   - default word address / data widths
//   - half-word width used by the two-phase write protocol
//   - request operation codes and FSM state encoding
package mem_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 12;
   localparam int HALF_W     = 6;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_DUMP  = 2'd2,
      OP_RSVD  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_WA_HI = 3'd2,
      S_WD_HI = 3'd3,
      S_WA_LO = 3'd4,
      S_WD_LO = 3'd5,
      S_DUMP  = 3'd6
   } state_e;

endpackage

// File: rtl/mem_bus_seq.sv
// mem_bus_seq: sequences single-word requests onto a downstream word memory
// that is written in two 6-bit halves (address phase, then data phase per half).
//
// Ports:
//   clk, rst_n             clock (rising edge) and async active-low reset
//   req_valid / req_ready  request handshake; ready only while idle
//   req_op                 READ=0, WRITE=1, DUMP=2, 3 reserved (answered, no bus activity)
//   req_addr, req_wdata    word address and write word, captured on acceptance
//   rsp_valid              one-cycle completion pulse
//   rsp_data               read word (held until next response), zero for other ops
//   read_write, write_commit, dump_mem, addr_data   memory bus
//   mem_result             combinational read data returned by the memory
module mem_bus_seq
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              read_write,
   output logic              write_commit,
   output logic              dump_mem,
   output logic [ADDR_W-1:0] addr_data,
   input  logic [DATA_W-1:0] mem_result
);

   state_e            state_r;
   state_e            state_nxt_s;
   logic [1:0]        op_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic              rsp_valid_r;
   logic [DATA_W-1:0] rsp_data_r;

   logic              accept_s;
   logic              rsvd_acc_s;
   logic              done_s;
   logic              rw_s;
   logic              commit_s;
   logic              dump_s;
   logic [ADDR_W-1:0] addr_data_s;

   // Handshake decode: only the idle state accepts, so req_* is ignored while busy.
   always_comb begin
      accept_s   = req_valid && (state_r == S_IDLE);
      rsvd_acc_s = accept_s && (req_op == OP_RSVD);
      done_s     = (state_r == S_RD) || (state_r == S_WD_LO) || (state_r == S_DUMP);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic and bus decode; the bus depends only on state_r and the
   // captured request so no req_* input can reach the memory combinationally.
   always_comb begin
      state_nxt_s = state_r;
      rw_s        = 1'b1;
      commit_s    = 1'b0;
      dump_s      = 1'b0;
      addr_data_s = {ADDR_W{1'b0}};
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               case (req_op)
                  OP_READ:  state_nxt_s = S_RD;
                  OP_WRITE: state_nxt_s = S_WA_HI;
                  OP_DUMP:  state_nxt_s = S_DUMP;
                  default:  state_nxt_s = S_IDLE;
               endcase
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_RD: begin
            addr_data_s = addr_r;
            state_nxt_s = S_IDLE;
         end
         S_WA_HI: begin
            rw_s        = 1'b0;
            addr_data_s = addr_r;
            state_nxt_s = S_WD_HI;
         end
         S_WD_HI: begin
            // Data phase: bit HALF_W tags the upper half, low bits carry the data.
            rw_s                      = 1'b0;
            commit_s                  = 1'b1;
            addr_data_s[HALF_W]       = 1'b1;
            addr_data_s[HALF_W-1:0]   = wdata_r[2*HALF_W-1:HALF_W];
            state_nxt_s               = S_WA_LO;
         end
         S_WA_LO: begin
            rw_s        = 1'b0;
            addr_data_s = addr_r;
            state_nxt_s = S_WD_LO;
         end
         S_WD_LO: begin
            rw_s                      = 1'b0;
            commit_s                  = 1'b1;
            addr_data_s[HALF_W]       = 1'b0;
            addr_data_s[HALF_W-1:0]   = wdata_r[HALF_W-1:0];
            state_nxt_s               = S_IDLE;
         end
         S_DUMP: begin
            dump_s      = 1'b1;
            state_nxt_s = S_IDLE;
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // Request capture on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r    <= 2'd0;
         addr_r  <= {ADDR_W{1'b0}};
         wdata_r <= {DATA_W{1'b0}};
      end else if (accept_s) begin
         op_r    <= req_op;
         addr_r  <= req_addr;
         wdata_r <= req_wdata;
      end else begin
         op_r    <= op_r;
         addr_r  <= addr_r;
         wdata_r <= wdata_r;
      end
   end

   // Response: pulse in the idle cycle after the last bus cycle (or right after a
   // reserved op); read data sampled from the memory at the end of RD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= {DATA_W{1'b0}};
      end else if (done_s) begin
         rsp_valid_r <= 1'b1;
         rsp_data_r  <= (op_r == OP_READ) ? mem_result : {DATA_W{1'b0}};
      end else if (rsvd_acc_s) begin
         rsp_valid_r <= 1'b1;
         rsp_data_r  <= {DATA_W{1'b0}};
      end else begin
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= rsp_data_r;
      end
   end

   assign req_ready    = (state_r == S_IDLE);
   assign rsp_valid    = rsp_valid_r;
   assign rsp_data     = rsp_data_r;
   assign read_write   = rw_s;
   assign write_commit = commit_s;
   assign dump_mem     = dump_s;
   assign addr_data    = addr_data_s;

endmodule

// File: tb/tb_mem_bus_seq.sv
// Self-checking bench for mem_bus_seq with a behavioural half-word memory.
module tb_mem_bus_seq;

   localparam logic [1:0] RD = 2'd0;
   localparam logic [1:0] WR = 2'd1;
   localparam logic [1:0] DM = 2'd2;
   localparam logic [1:0] RS = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'd0;
   logic [9:0]  req_addr = 10'd0;
   logic [11:0] req_wdata = 12'd0;
   logic        rsp_valid;
   logic [11:0] rsp_data;
   logic        read_write;
   logic        write_commit;
   logic        dump_mem;
   logic [9:0]  addr_data;
   logic [11:0] mem_result;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   mem_bus_seq #(.ADDR_W(10), .DATA_W(12)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .read_write(read_write), .write_commit(write_commit), .dump_mem(dump_mem),
      .addr_data(addr_data), .mem_result(mem_result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: address phase latches the word address, each commit writes
   // one half selected by addr_data[6]; reads are combinational.
   logic [11:0] mem [0:1023] = '{default: 12'h000};
   logic [9:0]  wa = 10'd0;
   always @(posedge clk) begin
      if (write_commit) begin
         if (addr_data[6]) mem[wa][11:6] <= addr_data[5:0];
         else              mem[wa][5:0]  <= addr_data[5:0];
      end else if (!read_write) begin
         wa <= addr_data;
      end
   end
   assign mem_result = mem[addr_data];

   typedef struct {
      logic [11:0] data;
      logic [11:0] alt;
      int          due;
   } exp_t;
   exp_t sbq[$];
   exp_t mon_e;

   typedef struct {
      logic [1:0]  op;
      logic [9:0]  addr;
      logic [11:0] wdata;
      logic [11:0] exp;
      int          lat;
   } vec_t;
   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor: pops the scoreboard on each rsp_valid pulse.
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got rsp_data %0h with no pending request (cycle %0d)", rsp_data, cyc);
         end else begin
            mon_e = sbq.pop_front();
            chk("rsp_cycle", cyc, mon_e.due);
            checks++;
            if (rsp_data !== mon_e.data && rsp_data !== mon_e.alt) begin
               errors++;
               $display("FAIL rsp_data: got %0h expected %0h (or %0h)", rsp_data, mon_e.data, mon_e.alt);
            end
         end
      end
   end

   // Present one request at a negedge, wait (bounded) for acceptance, push the
   // expected response. Returns at the negedge after the accept edge.
   task automatic send(input logic [1:0] op, input logic [9:0] addr, input logic [11:0] wd,
                       input logic [11:0] exp, input logic [11:0] alt, input int lat,
                       output logic rv_at_acc);
      int k;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      req_valid = 1'b1;
      k = 0;
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      rv_at_acc = rsp_valid;
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got req_ready 0 expected 1 for op %0d", op);
         req_valid = 1'b0;
      end else begin
         sbq.push_back('{exp, alt, cyc + lat});
         @(negedge clk);
         req_valid = 1'b0;
      end
   endtask

   task automatic chk_bus(input string name, input logic rw, input logic cm, input logic dp,
                          input logic [9:0] ad);
      chk({name, "_rw"}, read_write, rw);
      chk({name, "_commit"}, write_commit, cm);
      chk({name, "_dump"}, dump_mem, dp);
      chk({name, "_addr"}, addr_data, ad);
   endtask

   initial begin
      logic rv;
      int k;
      vecs[0] = '{WR, 10'h123, 12'h456, 12'h000, 5};
      vecs[1] = '{WR, 10'h000, 12'h001, 12'h000, 5};
      vecs[2] = '{WR, 10'h2C3, 12'h9C0, 12'h000, 5};
      vecs[3] = '{RD, 10'h123, 12'h000, 12'h456, 2};
      vecs[4] = '{RD, 10'h000, 12'hFFF, 12'h001, 2};
      vecs[5] = '{DM, 10'h0AA, 12'h777, 12'h000, 2};
      vecs[6] = '{RS, 10'h2C3, 12'h333, 12'h000, 1};
      vecs[7] = '{RD, 10'h2C3, 12'h000, 12'h9C0, 2};
      vecs[8] = '{RD, 10'h3AA, 12'h000, 12'h000, 2};
      vecs[9] = '{RD, 10'h005, 12'h000, 12'hABC, 2};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_data", rsp_data, 12'h000);
      chk_bus("rst_bus", 1'b1, 1'b0, 1'b0, 10'h000);
      rst_n = 1'b1;
      @(negedge clk);
      chk_bus("idle_bus", 1'b1, 1'b0, 1'b0, 10'h000);

      // WRITE 0x005/0xABC bus trace; req_* wiggled while busy must be ignored
      send(WR, 10'h005, 12'hABC, 12'h000, 12'h000, 5, rv);
      req_addr  = 10'h2AA;
      req_wdata = 12'h555;
      req_op    = RD;
      chk_bus("wa_hi", 1'b0, 1'b0, 1'b0, 10'h005);
      chk("busy_ready", req_ready, 1'b0);
      @(negedge clk);
      chk_bus("wd_hi", 1'b0, 1'b1, 1'b0, 10'h06A);
      @(negedge clk);
      chk_bus("wa_lo", 1'b0, 1'b0, 1'b0, 10'h005);
      @(negedge clk);
      chk_bus("wd_lo", 1'b0, 1'b1, 1'b0, 10'h03C);
      @(negedge clk);
      chk_bus("wr_done", 1'b1, 1'b0, 1'b0, 10'h000);
      chk("wr_rsp_valid", rsp_valid, 1'b1);

      // READ back
      send(RD, 10'h005, 12'h000, 12'hABC, 12'hABC, 2, rv);
      chk_bus("rd_bus", 1'b1, 1'b0, 1'b0, 10'h005);

      // Back-to-back WRITE then READ held valid
      send(WR, 10'h3FF, 12'hFFF, 12'h000, 12'h000, 5, rv);
      send(RD, 10'h3FF, 12'h000, 12'hFFF, 12'hFFF, 2, rv);
      chk("b2b_accept_on_rsp", rv, 1'b1);

      // DUMP: one cycle of dump_mem, no commit
      send(DM, 10'h123, 12'h000, 12'h000, 12'h000, 2, rv);
      chk_bus("dump", 1'b1, 1'b0, 1'b1, 10'h000);
      @(negedge clk);
      chk_bus("dump_after", 1'b1, 1'b0, 1'b0, 10'h000);

      // Reserved op: bus stays idle, response next cycle
      send(RS, 10'h155, 12'hFFF, 12'h000, 12'h000, 1, rv);
      chk_bus("rsvd", 1'b1, 1'b0, 1'b0, 10'h000);
      chk("rsvd_rsp_valid", rsp_valid, 1'b1);
      @(negedge clk);
      chk_bus("rsvd_after", 1'b1, 1'b0, 1'b0, 10'h000);

      // Table-driven vectors, issued back-to-back
      for (int i = 0; i < 10; i++) begin
         send(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].exp, vecs[i].lat, rv);
      end
      k = 0;
      while (sbq.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("table_drain", sbq.size(), 0);
      @(negedge clk);

      // Reset during WD_HI of WRITE 0x010/0x123 (rsp_data holds a nonzero word here)
      send(WR, 10'h010, 12'h123, 12'h000, 12'h000, 5, rv);
      @(negedge clk);
      chk_bus("mid_wd_hi", 1'b0, 1'b1, 1'b0, 10'h044);
      #1 rst_n = 1'b0;
      #1;
      sbq.delete();
      chk_bus("mid_rst_bus", 1'b1, 1'b0, 1'b0, 10'h000);
      chk("mid_rst_ready", req_ready, 1'b1);
      chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
      chk("mid_rst_rsp_data", rsp_data, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", req_ready, 1'b1);
      // Upper half alone (0x100) is tolerated; this memory model sees no commit.
      send(RD, 10'h010, 12'h000, 12'h000, 12'h100, 2, rv);
      k = 0;
      while (sbq.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("final_drain", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
